// File: rtl/alu_reg_unit.sv
// alu_reg_unit: 4 x 8-bit register file feeding an 8-bit ALU.
// Read port is the ALU B operand; immediate_input is operand A.
module alu_reg_unit #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  register_select,
  input  logic             mem_enable,
  input  logic             read_write,
  input  logic [WIDTH-1:0] data_bus_in,
  output logic [WIDTH-1:0] data_bus_out,
  input  logic             alu_enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] immediate_input,
  output logic [WIDTH-1:0] sum,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_PASSA = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_CMP   = 3'b111;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             wr_en;
  logic             rd_en;

  assign op_a  = immediate_input;
  assign op_b  = data_bus_out;
  assign wr_en = mem_enable & ~read_write;
  assign rd_en = mem_enable & read_write;

  // Register array: write when enabled for write, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[register_select] <= data_bus_in;
    end
  end

  // Registered read port; holds unless a read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_bus_out <= '0;
    else if (rd_en)
      data_bus_out <= regs[register_select];
  end

  // ALU datapath; carry is bit WIDTH of the extended add/sub.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (mode)
      OP_ADD:
        {res_c, res} = {1'b0, op_b} + {1'b0, op_a};
      OP_SUB, OP_CMP:
        {res_c, res} = {1'b0, op_b} - {1'b0, op_a};
      OP_PASSB: res = op_b;
      OP_PASSA: res = op_a;
      OP_AND:   res = op_b & op_a;
      OP_OR:    res = op_b | op_a;
      OP_XOR:   res = op_b ^ op_a;
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  // Result and flags update only on an enabled ALU cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum        <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (alu_enable) begin
      sum        <= res;
      zero_flag  <= (res == '0);
      carry_flag <= res_c;
    end
  end

endmodule

// File: tb/tb_alu_reg_unit.sv
// tb_alu_reg_unit: vector table plus hand sequences,
// expected outputs queued per cycle and checked after the edge.
module tb_alu_reg_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] register_select;
  logic       mem_enable;
  logic       read_write;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;
  logic       alu_enable;
  logic [2:0] mode;
  logic [7:0] immediate_input;
  logic [7:0] sum;
  logic       zero_flag;
  logic       carry_flag;

  alu_reg_unit dut (
    .clk             (clk),
    .rst             (rst),
    .register_select (register_select),
    .mem_enable      (mem_enable),
    .read_write      (read_write),
    .data_bus_in     (data_bus_in),
    .data_bus_out    (data_bus_out),
    .alu_enable      (alu_enable),
    .mode            (mode),
    .immediate_input (immediate_input),
    .sum             (sum),
    .zero_flag       (zero_flag),
    .carry_flag      (carry_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] dbo;
    logic [7:0] s;
    logic       z;
    logic       c;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic [2:0] md;
    logic [7:0] imm;
    logic [7:0] s;
    logic       z;
    logic       c;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [7:0] m_dbo;
  logic [7:0] m_sum;
  logic       m_z;
  logic       m_c;

  task automatic chk(input string name, input logic [7:0] d,
                     input logic [7:0] s, input logic z,
                     input logic c);
    tests++;
    if (data_bus_out !== d || sum !== s ||
        zero_flag !== z || carry_flag !== c) begin
      fails++;
      $display("FAIL %s: got dbo=%h sum=%h z=%b c=%b, want dbo=%h sum=%h z=%b c=%b",
               name, data_bus_out, sum, zero_flag, carry_flag,
               d, s, z, c);
    end
  endtask

  task automatic idle();
    mem_enable = 1'b0;
    read_write = 1'b1;
    alu_enable = 1'b0;
  endtask

  task automatic step(input string name);
    exp_t e;
    e.name = name;
    e.dbo  = m_dbo;
    e.s    = m_sum;
    e.z    = m_z;
    e.c    = m_c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, e.dbo, e.s, e.z, e.c);
    idle();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d,
                    input string name);
    mem_enable      = 1'b1;
    read_write      = 1'b0;
    register_select = sel;
    data_bus_in     = d;
    step(name);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] d,
                    input string name);
    mem_enable      = 1'b1;
    read_write      = 1'b1;
    register_select = sel;
    m_dbo           = d;
    step(name);
  endtask

  task automatic alu(input logic [2:0] md, input logic [7:0] imm,
                     input logic [7:0] s, input logic z,
                     input logic c, input string name);
    alu_enable      = 1'b1;
    mode            = md;
    immediate_input = imm;
    m_sum           = s;
    m_z             = z;
    m_c             = c;
    step(name);
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = '{8'h29, 3'b000, 8'h07, 8'h30, 1'b0, 1'b0};
    vt[1]  = '{8'hFF, 3'b000, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[2]  = '{8'h29, 3'b001, 8'h29, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{8'h29, 3'b001, 8'h30, 8'hF9, 1'b0, 1'b1};
    vt[4]  = '{8'h29, 3'b100, 8'h0F, 8'h09, 1'b0, 1'b0};
    vt[5]  = '{8'h29, 3'b101, 8'h50, 8'h79, 1'b0, 1'b0};
    vt[6]  = '{8'h29, 3'b110, 8'h29, 8'h00, 1'b1, 1'b0};
    vt[7]  = '{8'h29, 3'b111, 8'h29, 8'h00, 1'b1, 1'b0};
    vt[8]  = '{8'h29, 3'b111, 8'h30, 8'hF9, 1'b0, 1'b1};
    vt[9]  = '{8'h29, 3'b010, 8'h77, 8'h29, 1'b0, 1'b0};
    vt[10] = '{8'h29, 3'b011, 8'h5A, 8'h5A, 1'b0, 1'b0};
    vt[11] = '{8'h00, 3'b010, 8'h11, 8'h00, 1'b1, 1'b0};
    vt[12] = '{8'h80, 3'b000, 8'h80, 8'h00, 1'b1, 1'b1};
    vt[13] = '{8'h10, 3'b001, 8'h20, 8'hF0, 1'b0, 1'b1};

    rst             = 1'b1;
    register_select = '0;
    data_bus_in     = '0;
    mode            = '0;
    immediate_input = '0;
    idle();
    m_dbo = '0;
    m_sum = '0;
    m_z   = 1'b0;
    m_c   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    wr(2'd0, 8'h29, "wr_r0");
    rd(2'd0, 8'h29, "rd_r0");
    alu(3'b000, 8'h07, 8'h30, 1'b0, 1'b0, "pre_rst_add");

    #2 rst = 1'b1;
    #1 chk("async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    m_dbo = '0;
    m_sum = '0;
    m_z   = 1'b0;
    m_c   = 1'b0;
    wr(2'd0, 8'hAA, "rst_hold");
    rst = 1'b0;
    rd(2'd0, 8'h00, "rd_r0_after_rst");

    for (int i = 0; i < 14; i++) begin
      wr(2'd2, vt[i].b, $sformatf("v%0d_wr", i));
      rd(2'd2, vt[i].b, $sformatf("v%0d_rd", i));
      alu(vt[i].md, vt[i].imm, vt[i].s, vt[i].z, vt[i].c,
          $sformatf("v%0d_alu", i));
    end

    mode            = 3'b000;
    immediate_input = 8'h33;
    step("alu_hold");

    wr(2'd1, m_sum, "wb_r1");
    rd(2'd1, 8'hF0, "rd_wb_r1");

    register_select = 2'd3;
    step("mem_off_rd_hold");
    read_write      = 1'b0;
    register_select = 2'd1;
    data_bus_in     = 8'hEE;
    step("mem_off_wr_ign");
    rd(2'd1, 8'hF0, "rd_r1_kept");

    wr(2'd3, 8'h55, "wr_r3");
    rd(2'd3, 8'h55, "raw_r3");

    wr(2'd0, 8'h10, "wr_r0_nodbo");
    mem_enable      = 1'b1;
    read_write      = 1'b1;
    register_select = 2'd0;
    m_dbo           = 8'h10;
    alu(3'b000, 8'h01, 8'h56, 1'b0, 1'b0, "rd_alu_same_edge");
    alu(3'b000, 8'h01, 8'h11, 1'b0, 1'b0, "alu_after_rd");

    mem_enable      = 1'b1;
    read_write      = 1'b0;
    register_select = 2'd2;
    data_bus_in     = 8'h77;
    alu(3'b110, 8'h10, 8'h00, 1'b1, 1'b0, "wr_alu_same_edge");
    rd(2'd2, 8'h77, "rd_r2_after_wr_alu");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_reg_unit.md
Name: alu_reg_unit

Overview:
- Datapath slice containing a 4-entry x 8-bit register file and an 8-bit ALU.
- The register-file read port (data_bus_out) feeds the ALU register operand directly. The second operand is an external immediate.
- The sequencing controller drives enables, selects and mode, and writes the ALU result back through data_bus_in.

Parameters:
- WIDTH, 8, data width of registers, buses, immediate and result.
- NREGS, 4, number of registers; select width is log2(NREGS) = 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- register_select  input  2  register index for read or write.
- mem_enable  input  1  register-file access enable.
- read_write  input  1  1 = read, 0 = write; qualified by mem_enable.
- data_bus_in  input  8  write data.
- data_bus_out  output  8  registered read data; also the ALU operand B.
- alu_enable  input  1  ALU operation enable.
- mode  input  3  ALU operation select.
- immediate_input  input  8  ALU operand A.
- sum  output  8  registered ALU result.
- zero_flag  output  1  registered; 1 when the result is zero (see CMP).
- carry_flag  output  1  registered carry/borrow.

Behaviour:
- Reset (async, rst=1):
  - All registers, data_bus_out, sum, zero_flag and carry_flag go to 0 immediately.
  - Reset mid-operation aborts any access; outputs remain 0 until rst deasserts.
  - First rising edge with rst=0 resumes normal operation.
- Register write: on posedge, when mem_enable=1 and read_write=0, reg[register_select] <= data_bus_in. data_bus_out is unchanged.
- Register read: on posedge, when mem_enable=1 and read_write=1, data_bus_out <= reg[register_select]. Latency is 1 cycle.
- Read-after-write to the same register in the next cycle returns the new value.
- When mem_enable=0, the register file and data_bus_out hold.
- ALU timing:
  - On posedge with alu_enable=1, the ALU computes from the current immediate_input (A) and the current registered data_bus_out (B), then updates sum and both flags.
  - With alu_enable=0, sum and flags hold.
  - A value read at edge N is operated on at edge N+1 if alu_enable is high then.
  - If the read and alu_enable are in the same edge, the ALU uses the pre-read value of data_bus_out.
- ALU operations (B = register operand, A = immediate; arithmetic mod 256):
  - 000 ADD: sum = B + A; carry = bit 8 of the 9-bit sum.
  - 001 SUB: sum = B - A; carry = borrow (1 iff B < A unsigned).
  - 010 PASSB: sum = B; carry = 0.
  - 011 PASSA: sum = A; carry = 0.
  - 100 AND: B & A; carry = 0.
  - 101 OR: B | A; carry = 0.
  - 110 XOR: B ^ A; carry = 0.
  - 111 CMP: sum = B - A; carry = borrow (B < A); zero = (B == A).
- zero_flag = (new sum == 0) for every mode; for CMP this equals B == A.
- Simultaneous events:
  - Register write plus ALU enable in the same cycle is legal. The ALU uses the current data_bus_out; the write is unaffected.
  - Write-back of sum is done by the external controller through data_bus_in, at least one cycle after sum updates.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Write 0x29 to r0, read r0 -> data_bus_out=0x29 one edge later. Assert rst mid-sequence -> all outputs 0 asynchronously; r0 reads back 0.
- B=0x29, mode=000, A=0x07, alu_enable pulse -> sum=0x30, Z=0, C=0. Then B=0xFF, A=0x01 -> sum=0x00, Z=1, C=1.
- B=0x29, mode=001: A=0x29 -> sum=0x00, Z=1, C=0. A=0x30 -> sum=0xF9, Z=0, C=1.
- B=0x29, modes 100/101/110 with A=0x0F/0x50/0x29 -> sum=0x09 / 0x79 / 0x00 (Z=1); C=0 for all.
- CMP: B=0x29, A=0x29 -> Z=1, C=0. A=0x30 -> Z=0, C=1, sum=0xF9. PASSB/PASSA -> 0x29 / A.
- alu_enable=0 while mode/immediate change -> sum and flags hold. Write sum back to r1 via data_bus_in, read r1 -> same value. mem_enable=0 -> data_bus_out holds.
